// File: rtl/pll_lock_supervisor_pkg.sv
// Shared state encoding and sizing helper for the PLL lock supervisor.
package pll_lock_supervisor_pkg;

  typedef enum logic [2:0] {
    PRST = 3'd0,
    WAIT = 3'd1,
    STAB = 3'd2,
    REL  = 3'd3,
    RUN  = 3'd4,
    FAIL = 3'd5
  } state_t;

  // One spare bit above the limit so a counter can never wrap before its compare.
  function automatic int cnt_w(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the clkin domain.
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses the PLL reset, filters lock, releases downstream
// resets in staggered order, and supervises lock with retry and loss accounting.
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int NUM_CH           = 4,
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_FILT_CYC    = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int MAX_RETRY        = 7,
  parameter int STAGGER_CYC      = 8,
  parameter int CNT_W            = 8
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              pll_lock,
  input  logic              restart,
  input  logic              clear_cnt,
  output logic              pll_reset,
  output logic [NUM_CH-1:0] rst_out,
  output logic              ready,
  output logic              fail,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  retry_cnt,
  output logic [CNT_W-1:0]  loss_cnt
);

  localparam int PW = cnt_w(RST_PULSE_CYC);
  localparam int FW = cnt_w(LOCK_FILT_CYC);
  localparam int TW = cnt_w(LOCK_TIMEOUT_CYC);
  localparam int SW = cnt_w((NUM_CH - 1) * STAGGER_CYC + 1);

  localparam logic [PW-1:0]    PULSE_LAST = PW'(RST_PULSE_CYC - 1);
  localparam logic [FW-1:0]    FILT_LAST  = FW'(LOCK_FILT_CYC - 1);
  localparam logic [TW-1:0]    TMO_LAST   = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [SW-1:0]    STAG_LAST  = SW'((NUM_CH - 1) * STAGGER_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           st;
  logic             lock_s;
  logic [PW-1:0]    pulse;
  logic [FW-1:0]    filt;
  logic [TW-1:0]    tmo;
  logic [SW-1:0]    stag;
  logic [CNT_W-1:0] retry_inc;
  logic             loss_evt;

  pll_lock_sync u_sync (
    .clk (clkin),
    .rst (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

  assign state     = st;
  assign retry_inc = (retry_cnt == CNT_MAX) ? retry_cnt : retry_cnt + 1'b1;
  assign loss_evt  = (st == RUN) && !lock_s;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      st        <= PRST;
      pll_reset <= 1'b1;
      rst_out   <= '1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pulse     <= '0;
      filt      <= '0;
      tmo       <= '0;
      stag      <= '0;
    end else begin
      // Loss accounting is independent of restart; clear wins over a same-cycle loss.
      if (clear_cnt)
        loss_cnt <= '0;
      else if (loss_evt && loss_cnt != CNT_MAX)
        loss_cnt <= loss_cnt + 1'b1;

      if (restart) begin
        st        <= PRST;
        pll_reset <= 1'b1;
        pulse     <= '0;
        rst_out   <= '1;
        ready     <= 1'b0;
        fail      <= 1'b0;
        retry_cnt <= '0;
      end else begin
        case (st)
          PRST: begin
            if (pulse == PULSE_LAST) begin
              st        <= WAIT;
              pll_reset <= 1'b0;
              tmo       <= '0;
            end else begin
              pulse <= pulse + 1'b1;
            end
          end
          WAIT, STAB: begin
            // Timeout spans WAIT and STAB together, so lock bounces cannot extend it.
            if (tmo == TMO_LAST) begin
              retry_cnt <= retry_inc;
              pll_reset <= 1'b1;
              pulse     <= '0;
              if (MAX_RETRY != 0 && int'(retry_inc) == MAX_RETRY) begin
                st   <= FAIL;
                fail <= 1'b1;
              end else begin
                st <= PRST;
              end
            end else begin
              tmo <= tmo + 1'b1;
              if (st == WAIT) begin
                if (lock_s) begin
                  st   <= STAB;
                  filt <= '0;
                end
              end else if (!lock_s) begin
                st <= WAIT;
              end else if (filt == FILT_LAST) begin
                st         <= REL;
                stag       <= '0;
                rst_out[0] <= 1'b0;
              end else begin
                filt <= filt + 1'b1;
              end
            end
          end
          REL, RUN: begin
            if (!lock_s) begin
              st        <= PRST;
              pll_reset <= 1'b1;
              pulse     <= '0;
              rst_out   <= '1;
              ready     <= 1'b0;
            end else if (st == REL) begin
              if (stag == STAG_LAST) begin
                st        <= RUN;
                ready     <= 1'b1;
                retry_cnt <= '0;
              end else begin
                stag <= stag + 1'b1;
                for (int i = 1; i < NUM_CH; i++)
                  if (int'(stag) + 1 == i * STAGGER_CYC) rst_out[i] <= 1'b0;
              end
            end
          end
          FAIL: ;
          default: begin
            st        <= PRST;
            pll_reset <= 1'b1;
            pulse     <= '0;
            rst_out   <= '1;
            ready     <= 1'b0;
            fail      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
